// File: rtl/divider8_if.sv
// Control and status group for divider8.
// The shared 8-bit data bus is not part of this group: it stays a module-level inout net so
// every bus agent (divider, multiplier, host) resolves on one wire at the level that owns it.
//   ld_divisor / ld_dividend : host -> divider, capture the data bus into D / N
//   start                    : host -> divider, begin N / D
//   rd_quo / rd_rem          : host -> divider, drive Q / R[7:0] onto the data bus
//   busy / done / div_zero   : divider -> host status
//   data_oe                  : divider -> host, high while the divider drives the data bus
interface divider8_if;
  logic ld_divisor;
  logic ld_dividend;
  logic start;
  logic rd_quo;
  logic rd_rem;
  logic busy;
  logic done;
  logic div_zero;
  logic data_oe;

  modport master (
    output ld_divisor, ld_dividend, start, rd_quo, rd_rem,
    input  busy, done, div_zero, data_oe
  );

  modport slave (
    input  ld_divisor, ld_dividend, start, rd_quo, rd_rem,
    output busy, done, div_zero, data_oe
  );
endinterface

// File: rtl/divider8.sv
// Sequential 8-bit unsigned restoring divider on a shared bidirectional bus.
// The host loads D and N over data, pulses start, and after eight iterations reads Q and R.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   data  : shared bus, driven only while rd_quo or rd_rem is high, high-Z otherwise
//   bus   : control/status group (divider8_if.slave)
module divider8 (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire  [7:0] data,
  divider8_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  d_q, d_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  q_q, q_d;
  logic [8:0]  r_q, r_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d;

  logic        rd_any;
  logic [9:0]  r_wide;
  logic [9:0]  diff;
  logic [7:0]  data_out;

  assign rd_any = bus.rd_quo | bus.rd_rem;

  // {R, Q} shifted left by one; R[8] is always zero between iterations, so the top bit of the
  // 10-bit difference is the borrow of the 9-bit trial subtraction.
  assign r_wide = {r_q, q_q[7]};
  assign diff   = r_wide - {2'b00, d_q};

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    n_d     = n_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          // start outranks same-cycle loads and uses the stored operands
          dz_d = 1'b0;
          if (d_q == 8'd0) begin
            q_d     = 8'hFF;
            r_d     = {1'b0, n_q};
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            q_d     = n_q;
            r_d     = 9'd0;
            cnt_d   = 3'd0;
            state_d = StCalc;
          end
        end else if ((bus.ld_divisor || bus.ld_dividend) && !rd_any) begin
          if (bus.ld_divisor) begin
            d_d = data;
          end
          if (bus.ld_dividend) begin
            n_d = data;
          end
          dz_d    = 1'b0;
          state_d = StIdle;
        end
      end
      StCalc: begin
        if (!diff[9]) begin
          r_d = diff[8:0];
          q_d = {q_q[6:0], 1'b1};
        end else begin
          r_d = r_wide[8:0];
          q_d = {q_q[6:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      d_q     <= 8'd0;
      n_q     <= 8'd0;
      q_q     <= 8'd0;
      r_q     <= 9'd0;
      cnt_q   <= 3'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      n_q     <= n_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  // Read path is combinational; rd_quo wins when both strobes are high.
  assign data_out = bus.rd_quo ? q_q : r_q[7:0];
  assign data     = rd_any ? data_out : 8'bz;

  assign bus.data_oe  = rd_any;
  assign bus.busy     = (state_q == StCalc);
  assign bus.done     = (state_q == StDone);
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_divider8.sv
module tb_divider8;

  logic       clk;
  logic       rst_n;
  logic       tb_oe;
  logic [7:0] tb_data;
  wire  [7:0] data;

  divider8_if bus ();

  assign data = tb_oe ? tb_data : 8'bz;

  divider8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp;
  int         n_bad;
  logic [7:0] m_n;
  logic [7:0] m_d;

  function automatic void check(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endfunction

  // Reference: plain integer division on the operands the host believes are stored.
  function automatic void push_expect();
    exp_t e;
    if (m_d == 8'd0) begin
      e.q  = 8'hFF;
      e.r  = m_n;
      e.dz = 1'b1;
    end else begin
      e.q  = 8'(int'(m_n) / int'(m_d));
      e.r  = 8'(int'(m_n) % int'(m_d));
      e.dz = 1'b0;
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: on every rising edge of done, read Q then R and compare with the queue head.
  logic done_prev;
  initial begin
    exp_t       e;
    logic [7:0] q_rd;
    logic [7:0] r_rd;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !done_prev) begin
        bus.rd_quo = 1'b1;
        #1;
        q_rd = data;
        check("rd_oe", int'(bus.data_oe), 1);
        bus.rd_quo = 1'b0;
        bus.rd_rem = 1'b1;
        #1;
        r_rd = data;
        bus.rd_rem = 1'b0;
        if (exp_q.size() == 0) begin
          check("result_expected", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("quotient", int'(q_rd), int'(e.q));
          check("remainder", int'(r_rd), int'(e.r));
          check("div_zero", int'(bus.div_zero), int'(e.dz));
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic load_n(input logic [7:0] v);
    @(negedge clk);
    tb_data         = v;
    tb_oe           = 1'b1;
    bus.ld_dividend = 1'b1;
    @(negedge clk);
    bus.ld_dividend = 1'b0;
    tb_oe           = 1'b0;
    m_n             = v;
  endtask

  task automatic load_d(input logic [7:0] v);
    @(negedge clk);
    tb_data        = v;
    tb_oe          = 1'b1;
    bus.ld_divisor = 1'b1;
    @(negedge clk);
    bus.ld_divisor = 1'b0;
    tb_oe          = 1'b0;
    m_d            = v;
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or after the budget).
  task automatic wait_done(output int bc, output bit got);
    bc  = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) bc++;
      @(negedge clk);
    end
  endtask

  task automatic run_div(input int exp_busy);
    int bc;
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    push_expect();
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(bc, got);
    check("done_seen", int'(got), 1);
    check("busy_cycles", bc, exp_busy);
    @(negedge clk);
  endtask

  initial begin
    int          bc;
    bit          got;
    logic [7:0]  rn;
    logic [7:0]  rd;
    n_cmp           = 0;
    n_bad           = 0;
    m_n             = 8'd0;
    m_d             = 8'd0;
    tb_oe           = 1'b0;
    tb_data         = 8'd0;
    bus.ld_divisor  = 1'b0;
    bus.ld_dividend = 1'b0;
    bus.start       = 1'b0;
    bus.rd_quo      = 1'b0;
    bus.rd_rem      = 1'b0;
    rst_n           = 1'b0;
    #12;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_dz", int'(bus.div_zero), 0);
    check("rst_oe", int'(bus.data_oe), 0);
    bus.rd_quo = 1'b1;
    #1;
    check("rst_q", int'(data), 0);
    bus.rd_quo = 1'b0;
    bus.rd_rem = 1'b1;
    #1;
    check("rst_r", int'(data), 0);
    bus.rd_rem = 1'b0;
    #1;
    check("rst_oe_release", int'(bus.data_oe), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic case, then a repeat start without reload, then a load in DONE.
    load_n(8'd100);
    load_d(8'd7);
    run_div(8);
    run_div(8);
    load_d(8'd7);
    check("done_drop_on_load", int'(bus.done), 0);

    // Boundaries and divide-by-zero.
    load_n(8'd255); load_d(8'd1);   run_div(8);
    load_n(8'd5);   load_d(8'd9);   run_div(8);
    load_n(8'd255); load_d(8'd255); run_div(8);
    load_n(8'd0);   load_d(8'd3);   run_div(8);
    load_n(8'd42);  load_d(8'd0);   run_div(0);

    // Disturbances mid-run: start + load, then a read; none may alter the iteration.
    load_n(8'd200);
    load_d(8'd13);
    @(negedge clk);
    bus.start = 1'b1;
    push_expect();
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.ld_divisor = 1'b1;
    tb_data        = 8'd1;
    tb_oe          = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.ld_divisor = 1'b0;
    tb_oe          = 1'b0;
    bus.rd_quo     = 1'b1;
    #1;
    check("mid_oe_on", int'(bus.data_oe), 1);
    check("mid_busy", int'(bus.busy), 1);
    @(negedge clk);
    bus.rd_quo = 1'b0;
    #1;
    check("mid_oe_off", int'(bus.data_oe), 0);
    wait_done(bc, got);
    check("mid_done_seen", int'(got), 1);
    @(negedge clk);
    run_div(8);  // D must still be 13

    // Reset in the middle of a run.
    load_n(8'd150);
    load_d(8'd4);
    @(negedge clk);
    bus.start = 1'b1;
    push_expect();
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", int'(bus.busy), 0);
    check("rstmid_done", int'(bus.done), 0);
    check("rstmid_dz", int'(bus.div_zero), 0);
    check("rstmid_oe", int'(bus.data_oe), 0);
    void'(exp_q.pop_back());
    m_n = 8'd0;
    m_d = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    load_n(8'd9);
    load_d(8'd2);
    run_div(8);

    // start held high: done lasts exactly one cycle, then a new run begins.
    load_n(8'd100);
    load_d(8'd7);
    @(negedge clk);
    bus.start = 1'b1;
    push_expect();
    @(negedge clk);
    wait_done(bc, got);
    check("held_done_seen", int'(got), 1);
    check("held_busy", bc, 8);
    push_expect();
    @(negedge clk);
    check("held_done_1cyc", int'(bus.done), 0);
    check("held_restart", int'(bus.busy), 1);
    bus.start = 1'b0;
    wait_done(bc, got);
    check("held_done2_seen", int'(got), 1);
    @(negedge clk);

    // Random operands, divisor occasionally zero.
    for (int k = 0; k < 25; k++) begin
      rn = 8'($urandom_range(0, 255));
      rd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      load_n(rn);
      load_d(rd);
      run_div((rd == 8'd0) ? 0 : 8);
    end

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
